// File: rtl/fnd_pkg.sv
// Shared definitions for FND display blocks: active-low segment fonts,
// result-display FSM encoding and the double-dabble nibble correction.
package fnd_pkg;

    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] FONT_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } fsm_state_t;

    // A nibble of 5 or more must be bumped by 3 so the next shift carries into the next decade.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bcd_to_fnd_font.sv
// Combinational BCD digit to active-low 7-segment font ({dp,g,f,e,d,c,b,a}).
// Codes above 9 render as a dash.
module bcd_to_fnd_font
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] font
);

    // Segment lookup
    always_comb begin
        font = FONT_DASH;
        case (bcd)
            4'd0:    font = FONT_0;
            4'd1:    font = FONT_1;
            4'd2:    font = FONT_2;
            4'd3:    font = FONT_3;
            4'd4:    font = FONT_4;
            4'd5:    font = FONT_5;
            4'd6:    font = FONT_6;
            4'd7:    font = FONT_7;
            4'd8:    font = FONT_8;
            4'd9:    font = FONT_9;
            default: font = FONT_DASH;
        endcase
    end

endmodule

// File: rtl/fnd_result_display.sv
// Result display: sequential double-dabble binary-to-BCD conversion feeding a
// time-multiplexed common-anode FND; only completed conversions reach the digits.
module fnd_result_display
    import fnd_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_busy,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_fndCom,
    output logic [7:0]            o_fndFont
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    fsm_state_t          state_r;
    fsm_state_t          state_nxt_s;
    logic                capture_s;
    logic                shift_s;
    logic                load_s;

    logic [DATA_W-1:0]   bin_r;
    logic [BCD_W-1:0]    acc_r;
    logic [BCD_W-1:0]    acc_adj_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic                busy_r;
    logic [BCD_W-1:0]    bcd_r;

    logic [PRE_W-1:0]    presc_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DIGITS-1:0]   com_r;
    logic [7:0]          font_r;

    logic [3:0]          cur_nib_s;
    logic [DIGITS-1:0]   lz_s;
    logic [DIGITS-1:0]   one_hot_s;
    logic                blank_s;
    logic [7:0]          dec_font_s;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_LOAD: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM datapath controls
    always_comb begin
        capture_s = 1'b0;
        shift_s   = 1'b0;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE:  capture_s = i_valid;
            ST_SHIFT: shift_s   = 1'b1;
            ST_LOAD:  load_s    = 1'b1;
            default: begin
                capture_s = 1'b0;
                shift_s   = 1'b0;
                load_s    = 1'b0;
            end
        endcase
    end

    // Per-nibble add-3 correction applied before each shift
    always_comb begin
        acc_adj_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            acc_adj_s[4*k +: 4] = dabble_adjust(acc_r[4*k +: 4]);
        end
    end

    // Double-dabble shift register and bit counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bin_r     <= '0;
            acc_r     <= '0;
            bit_cnt_r <= '0;
        end else if (capture_s) begin
            bin_r     <= i_data;
            acc_r     <= '0;
            bit_cnt_r <= '0;
        end else if (shift_s) begin
            {acc_r, bin_r} <= {acc_adj_s[BCD_W-2:0], bin_r, 1'b0};
            bit_cnt_r      <= bit_cnt_r + CNT_W'(1);
        end else begin
            bin_r     <= bin_r;
            acc_r     <= acc_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Busy flag and published BCD result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_r <= 1'b0;
            bcd_r  <= '0;
        end else if (capture_s) begin
            busy_r <= 1'b1;
        end else if (load_s) begin
            busy_r <= 1'b0;
            bcd_r  <= acc_r;
        end else begin
            busy_r <= busy_r;
            bcd_r  <= bcd_r;
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (presc_r == PRE_W'(SCAN_DIV - 1)) begin
            presc_r <= '0;
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            presc_r <= presc_r + PRE_W'(1);
            idx_r   <= idx_r;
        end
    end

    // lz_s[k] is set when nibbles k..DIGITS-1 are all zero
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_s      = '0;
        cur_nib_s = 4'd0;
        one_hot_s = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run  = zero_run && (bcd_r[4*k +: 4] == 4'd0);
            lz_s[k]   = zero_run;
            cur_nib_s = (IDX_W'(k) == idx_r) ? bcd_r[4*k +: 4] : cur_nib_s;
        end
        one_hot_s[idx_r] = 1'b1;
        blank_s = (BLANK_LZ != 0) && (idx_r != '0) && lz_s[idx_r];
    end

    bcd_to_fnd_font u_font (
        .bcd  (cur_nib_s),
        .font (dec_font_s)
    );

    // Registered digit enable and segment drive
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            com_r  <= '1;
            font_r <= FONT_BLANK;
        end else begin
            com_r  <= ~one_hot_s;
            font_r <= blank_s ? FONT_BLANK : dec_font_s;
        end
    end

    assign o_busy    = busy_r;
    assign o_bcd     = bcd_r;
    assign o_fndCom  = com_r;
    assign o_fndFont = font_r;

endmodule

// File: tb/tb_fnd_result_display.sv
// Self-checking bench: a decimal-arithmetic reference model checked every cycle,
// plus directed literal checks, on two DUTs (leading-zero blanking on and off).
module tb_fnd_result_display;

    localparam int DATA_W   = 4;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic [DATA_W-1:0] data;

    logic              busy_a,  busy_b;
    logic [15:0]       bcd_a,   bcd_b;
    logic [3:0]        com_a,   com_b;
    logic [7:0]        font_a,  font_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit cmp_en   = 1'b0;

    fnd_result_display #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_data(data),
        .o_busy(busy_a), .o_bcd(bcd_a), .o_fndCom(com_a), .o_fndFont(font_a)
    );

    fnd_result_display #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nb (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_data(data),
        .o_busy(busy_b), .o_bcd(bcd_b), .o_fndCom(com_b), .o_fndFont(font_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = 16'h0000;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_font(input int v, input int idx, input bit blank);
        if (blank && idx > 0 && v < pow10(idx)) return 8'hFF;
        return font_tab[(v / pow10(idx)) % 10];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: conversion is a countdown of DATA_W+1 cycles, display is decimal arithmetic
    int         m_k, m_val, m_pend, m_cnt, m_idx;
    bit         m_busy;
    logic [3:0] m_com, m_one;
    logic [7:0] m_font_a, m_font_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_val = 0; m_pend = 0; m_cnt = 0; m_busy = 1'b0;
            m_com = 4'hF; m_font_a = 8'hFF; m_font_b = 8'hFF;
        end else begin
            m_k++;
            m_idx    = ((m_k - 1) / SCAN_DIV) % DIGITS;
            m_one    = 4'b0001;
            m_com    = ~(m_one << m_idx);
            m_font_a = exp_font(m_val, m_idx, 1'b1);
            m_font_b = exp_font(m_val, m_idx, 1'b0);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_val  = m_pend;
                    m_busy = 1'b0;
                end
            end else if (valid) begin
                m_pend = int'(data);
                m_cnt  = DATA_W + 1;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",    {31'd0, busy_a}, {31'd0, m_busy});
            chk("bcd",     {16'd0, bcd_a},  {16'd0, to_bcd(m_val)});
            chk("com",     {28'd0, com_a},  {28'd0, m_com});
            chk("font",    {24'd0, font_a}, {24'd0, m_font_a});
            chk("com_nb",  {28'd0, com_b},  {28'd0, m_com});
            chk("font_nb", {24'd0, font_b}, {24'd0, m_font_b});
        end
    end

    task automatic strobe(input logic [DATA_W-1:0] v);
        valid = 1'b1;
        data  = v;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp_a, input logic [7:0] exp_b);
        logic [3:0] want;
        int n = 0;
        want = 4'b0001;
        want = ~(want << d);
        while (com_a !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            chk("scan_timeout", {28'd0, com_a}, {28'd0, want});
        end else begin
            chk($sformatf("dig%0d", d),    {24'd0, font_a}, {24'd0, exp_a});
            chk($sformatf("dig%0d_nb", d), {24'd0, font_b}, {24'd0, exp_b});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; valid = 1'b0; data = '0;
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_com",  {28'd0, com_a},  32'h0000000F);
        chk("rst_font", {24'd0, font_a}, 32'h000000FF);
        chk("rst_bcd",  {16'd0, bcd_a},  32'h00000000);
        chk("rst_busy", {31'd0, busy_a}, 32'h00000000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 13 with an ignored strobe of 7 at cycle 2
        strobe(4'd13);
        chk("busy_c0", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        strobe(4'd7);
        repeat (2) @(negedge clk);
        chk("busy_c4", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        chk("busy_c5", {31'd0, busy_a}, 32'd0);
        chk("bcd_13",  {16'd0, bcd_a},  32'h00000013);
        @(negedge clk);
        check_digit(0, 8'hB0, 8'hB0);
        check_digit(1, 8'hF9, 8'hF9);
        check_digit(2, 8'hFF, 8'hC0);
        check_digit(3, 8'hFF, 8'hC0);

        // zero result
        strobe(4'd0);
        repeat (5) @(negedge clk);
        chk("bcd_0", {16'd0, bcd_a}, 32'h00000000);
        @(negedge clk);
        check_digit(0, 8'hC0, 8'hC0);
        check_digit(1, 8'hFF, 8'hC0);
        check_digit(2, 8'hFF, 8'hC0);
        check_digit(3, 8'hFF, 8'hC0);

        // reset in the middle of converting 15
        strobe(4'd15);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_bcd",  {16'd0, bcd_a},  32'h00000000);
        chk("arst_com",  {28'd0, com_a},  32'h0000000F);
        chk("arst_font", {24'd0, font_a}, 32'h000000FF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_busy", {31'd0, busy_a}, 32'd0);
        chk("rel_bcd",  {16'd0, bcd_a},  32'h00000000);
        chk("rel_com",  {28'd0, com_a},  32'h0000000E);

        // back-to-back 9 then 10 on the first IDLE cycle
        strobe(4'd9);
        repeat (5) @(negedge clk);
        chk("bcd_9", {16'd0, bcd_a}, 32'h00000009);
        strobe(4'd10);
        chk("busy_b2b", {31'd0, busy_a}, 32'd1);
        repeat (5) @(negedge clk);
        chk("bcd_10", {16'd0, bcd_a}, 32'h00000010);
        @(negedge clk);
        check_digit(1, 8'hF9, 8'hF9);
        check_digit(0, 8'hC0, 8'hC0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
